// File: rtl/picorv32_trace_pkg.sv
// Shared definitions for the picorv32 trace buffer: capture states,
// Wishbone register offsets, CTRL bit indices and STATUS field positions.
package picorv32_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } trace_state_t;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_WPTR     = 3'd2;
    localparam logic [2:0] REG_RIDX     = 3'd3;
    localparam logic [2:0] REG_RDATA_LO = 3'd4;
    localparam logic [2:0] REG_RDATA_HI = 3'd5;
    localparam logic [2:0] REG_TSTAMP   = 3'd6;
    localparam logic [2:0] REG_RSVD     = 3'd7;

    localparam int CTRL_ARM          = 0;
    localparam int CTRL_STOP_ON_TRAP = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int CTRL_STOP         = 3;
    localparam int CTRL_ONESHOT      = 4;

    localparam int STATUS_STATE_LSB   = 0;
    localparam int STATUS_WRAPPED_BIT = 8;
    localparam int STATUS_COUNT_LSB   = 16;
    localparam int STATUS_COUNT_WIDTH = 16;

    localparam int TSTAMP_WIDTH = 32;

endpackage

// File: rtl/trace_buf_ram.sv
// Simple dual-port RAM for the trace buffer: one write port, one
// synchronous read port with a single cycle of read latency.
module trace_buf_ram #(
    parameter int WIDTH      = 36,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/picorv32_trace_buffer.sv
// Circular capture buffer for the picorv32 instruction trace stream with a
// Wishbone classic slave for readback. Capture can be frozen by firmware,
// by a CPU trap, or when a one-shot fill completes, optionally raising irq_o.
// Optional feature: define TRACE_BUF_TIMESTAMP_EN to store a 32-bit cycle
// timestamp next to every captured word (readable at offset 6).
module picorv32_trace_buffer
    import picorv32_trace_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int TRACE_WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_valid_i,
    input  logic [TRACE_WIDTH-1:0] trace_data_i,
    input  logic                   trap_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [2:0]             wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   irq_o
);

`ifdef TRACE_BUF_TIMESTAMP_EN
    localparam int RAM_WIDTH = TRACE_WIDTH + TSTAMP_WIDTH;
`else
    localparam int RAM_WIDTH = TRACE_WIDTH;
`endif

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] LAST_PTR   = {DEPTH_LOG2{1'b1}};

    trace_state_t            state;
    trace_state_t            state_next;
    logic [DEPTH_LOG2-1:0]   wptr;
    logic [DEPTH_LOG2-1:0]   ridx;
    logic [DEPTH_LOG2:0]     count;
    logic [DEPTH_LOG2:0]     count_inc;
    logic                    wrapped;
    logic                    stop_on_trap;
    logic                    irq_en;
    logic                    oneshot;
    logic                    wb_req;
    logic                    wb_wr;
    logic                    ctrl_wr;
    logic                    arm_cmd;
    logic                    stop_cmd;
    logic                    ram_we;
    logic [RAM_WIDTH-1:0]    ram_wdata;
    logic [RAM_WIDTH-1:0]    ram_rdata;
    logic [63:0]             rdata_ext;
    logic [31:0]             rd_mux;
    logic                    unused_wb_dat;

    assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wb_wr    = wb_req & wb_we_i;
    assign ctrl_wr  = wb_wr & (wb_adr_i == REG_CTRL);
    assign arm_cmd  = ctrl_wr & wb_dat_i[CTRL_ARM];
    assign stop_cmd = ctrl_wr & wb_dat_i[CTRL_STOP];

    // ARM takes priority over a word arriving in the same cycle, and reset
    // blocks the write so an aborted capture leaves no partial entry.
    assign ram_we    = rst & (state == CAPTURE) & trace_valid_i & ~arm_cmd;
    assign count_inc = (count == FULL_COUNT) ? count : count + 1'b1;

    assign unused_wb_dat = ^wb_dat_i[31:5];

`ifdef TRACE_BUF_TIMESTAMP_EN
    logic [TSTAMP_WIDTH-1:0] tstamp;

    // Free-running cycle counter, wrapping naturally at 2**32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tstamp <= '0;
        end else begin
            tstamp <= tstamp + 1'b1;
        end
    end

    assign ram_wdata = {tstamp, trace_data_i};
`else
    assign ram_wdata = trace_data_i;
`endif

    trace_buf_ram #(
        .WIDTH      (RAM_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr),
        .wdata (ram_wdata),
        .raddr (ridx),
        .rdata (ram_rdata)
    );

    // Capture state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: ARM restarts from anywhere; a frozen trigger only counts in CAPTURE.
    always_comb begin
        state_next = state;
        if (arm_cmd) begin
            state_next = CAPTURE;
        end else if (state == CAPTURE) begin
            if (stop_cmd || (trap_i && stop_on_trap) ||
                (oneshot && ram_we && (count_inc == FULL_COUNT))) begin
                state_next = FROZEN;
            end
        end
    end

    // Write pointer, fill count, wrap flag, CTRL bits and read index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr         <= '0;
            ridx         <= '0;
            count        <= '0;
            wrapped      <= 1'b0;
            stop_on_trap <= 1'b0;
            irq_en       <= 1'b0;
            oneshot      <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                stop_on_trap <= wb_dat_i[CTRL_STOP_ON_TRAP];
                irq_en       <= wb_dat_i[CTRL_IRQ_EN];
                oneshot      <= wb_dat_i[CTRL_ONESHOT];
            end
            if (arm_cmd) begin
                wptr    <= '0;
                count   <= '0;
                wrapped <= 1'b0;
            end else if (ram_we) begin
                wptr  <= wptr + 1'b1;
                count <= count_inc;
                if (wptr == LAST_PTR) begin
                    wrapped <= 1'b1;
                end
            end
            if (wb_wr && (wb_adr_i == REG_RIDX)) begin
                ridx <= wb_dat_i[DEPTH_LOG2-1:0];
            end else if (wb_req && !wb_we_i && (wb_adr_i == REG_RDATA_HI)) begin
                ridx <= ridx + 1'b1;
            end
        end
    end

    assign rdata_ext = 64'(ram_rdata[TRACE_WIDTH-1:0]);

    // Register readback multiplexer; unmapped or disabled offsets read 0.
    always_comb begin
        rd_mux = '0;
        case (wb_adr_i)
            REG_CTRL: begin
                rd_mux[CTRL_STOP_ON_TRAP] = stop_on_trap;
                rd_mux[CTRL_IRQ_EN]       = irq_en;
                rd_mux[CTRL_ONESHOT]      = oneshot;
            end
            REG_STATUS: begin
                rd_mux[STATUS_STATE_LSB +: 2]                  = state;
                rd_mux[STATUS_WRAPPED_BIT]                     = wrapped;
                rd_mux[STATUS_COUNT_LSB +: STATUS_COUNT_WIDTH] = STATUS_COUNT_WIDTH'(count);
            end
            REG_WPTR:     rd_mux = 32'(wptr);
            REG_RIDX:     rd_mux = 32'(ridx);
            REG_RDATA_LO: rd_mux = rdata_ext[31:0];
            REG_RDATA_HI: rd_mux = rdata_ext[63:32];
`ifdef TRACE_BUF_TIMESTAMP_EN
            REG_TSTAMP:   rd_mux = ram_rdata[RAM_WIDTH-1 -: TSTAMP_WIDTH];
`endif
            default:      rd_mux = '0;
        endcase
    end

    // Single-cycle ack; the registered ack forces a gap between accesses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= (wb_req && !wb_we_i) ? rd_mux : '0;
        end
    end

    // Frozen interrupt, one cycle behind the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (state == FROZEN) & irq_en;
        end
    end

endmodule

// File: doc/picorv32_trace_buffer.md
Name: picorv32_trace_buffer

Overview:
- Captures the CPU instruction trace stream (valid + 36-bit word) into an on-chip circular buffer.
- Sits downstream of the picorv32 demo system trace port.
- Firmware or debug logic reads the buffer through a Wishbone classic slave.
- Can freeze on CPU trap and raise an interrupt, so the last DEPTH retired trace words survive a crash.

Parameters:
- DEPTH_LOG2, 8, log2 of buffer entries (DEPTH = 2**DEPTH_LOG2, 256 default).
- TRACE_WIDTH, 36, trace word width; must be ≤ 64.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- trace_valid_i  in  1  trace word qualifier
- trace_data_i  in  TRACE_WIDTH  trace word
- trap_i  in  1  CPU trap indication (level)
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  3  word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- irq_o  out  1  buffer-frozen interrupt (level)

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; wptr, ridx, count, wrapped, ctrl bits = 0.
  - wb_ack_o=0, wb_dat_o=0, irq_o=0.
  - RAM contents are not cleared.
  - Reset mid-capture aborts immediately; no partial write.
- States (STATUS[1:0]): IDLE=0, CAPTURE=1, FROZEN=2.
  - IDLE/FROZEN -> CAPTURE on CTRL write with bit0 (ARM)=1. Clears wptr, count, wrapped.
  - CAPTURE -> FROZEN on CTRL write with bit3 (STOP)=1, or on trap_i=1 while CTRL.bit1 (STOP_ON_TRAP)=1.
  - CAPTURE -> FROZEN on count reaching DEPTH while CTRL.bit4 (ONESHOT)=1.
- Capture:
  - In CAPTURE, each cycle with trace_valid_i=1 writes trace_data_i to RAM[wptr].
  - wptr increments mod DEPTH.
  - count increments, saturating at DEPTH.
  - wrapped is set when wptr rolls DEPTH-1 -> 0.
  - Writes are visible in RAM the next cycle.
- Simultaneous events:
  - ARM write and trace_valid_i in the same cycle: ARM wins; the word is not stored.
  - trap_i and trace_valid_i in the same cycle: the word is stored, then FROZEN.
  - ARM and trap_i in the same cycle: ARM wins; the trap is ignored that cycle.
- irq_o = (state==FROZEN) & CTRL.bit2 (IRQ_EN), registered, 1-cycle latency. Cleared by the next ARM.
- Wishbone:
  - Classic, single-cycle ack: wb_ack_o=1 on the cycle after cyc&stb&!ack.
  - At most one ack every two cycles. wb_dat_o is valid with ack.
  - wb_sel is ignored.
- Register map (word offsets):
  - 0 CTRL, RW: bits[4:0] as above. ARM and STOP are self-clearing and read 0.
  - 1 STATUS, RO: [1:0] state, [8] wrapped, [31:16] count.
  - 2 WPTR, RO: zero-extended wptr.
  - 3 RIDX, RW: read index mod DEPTH.
  - 4 RDATA_LO, RO: RAM[ridx][31:0].
  - 5 RDATA_HI, RO: RAM[ridx][TRACE_WIDTH-1:32], zero-padded. A read post-increments ridx mod DEPTH on the ack cycle.
  - 6 TSTAMP: see Optional Feature.
  - 7: reads 0.
  - Writes to RO offsets are ignored but still acked.
- RAM: one write port, one synchronous read port continuously addressed by ridx (1-cycle latency). The Wishbone ack spacing guarantees fresh data after any ridx change.
- Reading during CAPTURE is permitted. Data may be overwritten concurrently; no hazard protection.

Optional Feature:
- Macro TRACE_BUF_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter (reset 0, wraps at 2**32) is stored alongside each captured word.
  - Offset 6 returns the stored timestamp of RAM[ridx].
- Undefined:
  - No counter and no extra RAM width.
  - Offset 6 reads 0.

Decomposition:
- Shared package picorv32_trace_pkg holds:
  - state encodings IDLE/CAPTURE/FROZEN;
  - register offsets 0-7;
  - CTRL bit indices (ARM=0, STOP_ON_TRAP=1, IRQ_EN=2, STOP=3, ONESHOT=4);
  - STATUS field positions.
- One sub-module, trace_buf_ram: simple dual-port RAM, width TRACE_WIDTH (+32 with timestamp), depth DEPTH, synchronous read, inferrable.

Test Plan:
- Reset check: after rst=0, STATUS reads 0x00000000, WPTR=0, irq_o=0, no ack without stb.
- Arm, then 5 valid words 0x0_0000_0001..0x0_0000_0005; set RIDX=0 and read LO/HI ×5 -> LO=1..5, HI=0, STATUS count=5, state=1.
- DEPTH_LOG2=2: arm, 6 words 0xA..0xF -> WPTR=2, wrapped=1, count=4, RAM[0..3]=0xE,0xF,0xC,0xD.
- CTRL=0x6: arm, 3 words, trap_i with a valid word 0x8_1234_5678 -> state=2, count=4, RDATA_HI=0x8 at idx 3, irq_o=1 one cycle later; further valid words are not stored.
- ARM write coincident with trace_valid_i -> count=0 after that cycle. Reset asserted mid-capture -> state=0, WPTR=0.
- With TRACE_BUF_TIMESTAMP_EN: words 10 cycles apart -> TSTAMP difference of consecutive entries = 10.
